// File: rtl/router_src_rx.sv
// router_src_rx: receive side of the router source port. Parses the header, streams header/payload/parity
// into one of NUM_DEST FIFOs and flags parity/length/address errors. Optional stall abort: ROUTER_RX_TIMEOUT_EN.
module router_src_rx #(
    parameter int NUM_DEST       = 3,
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [7:0]          data_in,
    input  logic                pkt_valid,
    output logic                busy,
    output logic                err,
    input  logic [NUM_DEST-1:0] fifo_full,
    input  logic [NUM_DEST-1:0] fifo_empty,
    output logic [NUM_DEST-1:0] wr_en,
    output logic [7:0]          wr_data,
    output logic                pkt_done,
    output logic [2:0]          dbg_state
);

    // Handshake: a byte on data_in/pkt_valid is consumed at a rising edge only when busy=0 just before
    // that edge; while busy=1 the source holds data_in/pkt_valid unchanged.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_EMPTY = 3'd1,
        S_LOAD       = 3'd2,
        S_CHECK      = 3'd3,
        S_DROP       = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          hold_q, hold_d;
    logic [7:0]          parity_q, parity_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                mismatch_q, mismatch_d;
    logic                err_q, err_d;
    logic [NUM_DEST-1:0] wr_en_q, wr_en_d;
    logic [7:0]          wr_data_q, wr_data_d;

    logic [NUM_DEST-1:0] dest_oh;
    logic                sel_full;
    logic                sel_empty;
    logic                hdr_ok;
    logic                busy_c;
    logic                done_c;
    logic                stall_c;

    always_comb begin
        dest_oh = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (hold_q[1:0] == 2'(i)) dest_oh[i] = 1'b1;
        end
    end

    assign sel_full  = |(fifo_full & dest_oh);
    assign sel_empty = |(fifo_empty & dest_oh);
    assign hdr_ok    = (data_in[1:0] != 2'b11) && (int'(data_in[1:0]) < NUM_DEST);

`ifdef ROUTER_RX_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               stall_hit;
    assign stall_hit = (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = stall_c | (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        parity_d   = parity_q;
        cnt_d      = cnt_q;
        mismatch_d = mismatch_q;
        err_d      = err_q;
        wr_en_d    = '0;
        wr_data_d  = wr_data_q;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        stall_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pkt_valid) begin
                    if (hdr_ok) begin
                        hold_d   = data_in;
                        parity_d = data_in;
                        cnt_d    = '0;
                        err_d    = 1'b0;
                        state_d  = S_WAIT_EMPTY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DROP;
                    end
                end
            end
            S_WAIT_EMPTY: begin
                busy_c = 1'b1;
                if (sel_empty && !sel_full) begin
                    wr_en_d   = dest_oh;
                    wr_data_d = hold_q;
                    state_d   = S_LOAD;
                end else begin
                    stall_c = 1'b1;
                end
            end
            S_LOAD: begin
                busy_c = sel_full;
                if (!sel_full) begin
                    wr_en_d   = dest_oh;
                    wr_data_d = data_in;
                    if (pkt_valid) begin
                        parity_d = parity_q ^ data_in;
                        if (cnt_q != 6'h3F) cnt_d = cnt_q + 6'd1;
                    end else begin
                        // Length is checked against the saturated count, so len=63 with 64+ bytes passes
                        mismatch_d = (data_in != parity_q) || (cnt_q != hold_q[7:2]);
                        state_d    = S_CHECK;
                    end
                end else begin
                    stall_c = 1'b1;
                end
            end
            S_CHECK: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                err_d   = mismatch_q;
                state_d = S_IDLE;
            end
            S_DROP: begin
                if (!pkt_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ROUTER_RX_TIMEOUT_EN
        stall_d = '0;
        if (stall_c) begin
            if (stall_hit) begin
                err_d   = 1'b1;
                wr_en_d = '0;
                state_d = S_DROP;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            parity_q   <= '0;
            cnt_q      <= '0;
            mismatch_q <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            parity_q   <= parity_d;
            cnt_q      <= cnt_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
        end
    end

`ifdef ROUTER_RX_TIMEOUT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) stall_q <= '0;
        else         stall_q <= stall_d;
    end
`endif

    assign busy      = busy_c;
    assign pkt_done  = done_c;
    assign err       = err_q;
    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign dbg_state = state_q;

endmodule
